// File: rtl/dmem_if.sv
// EX-stage data-memory request bus and ME-stage response, seen from the pipeline
// (master) and from the memory responder (slave).
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic [ADDR_W-1:0] i_req_addr;
    logic [WORD_W-1:0] i_req_wr_data;
    logic              i_req_wr_en;
    logic [1:0]        i_req_count;
    logic              i_req_unsigned;
    logic              o_stall;
    logic [WORD_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              o_misaligned;

    modport master (
        output i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count, i_req_unsigned,
        input  o_stall, o_rd_data, o_rd_valid, o_misaligned
    );

    modport slave (
        input  i_req_addr, i_req_wr_data, i_req_wr_en, i_req_count, i_req_unsigned,
        output o_stall, o_rd_data, o_rd_valid, o_misaligned
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with a fixed access latency. It stalls the pipeline while an
// access is in flight and returns aligned, extended load data for one DONE cycle.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic   clk,
    input  logic   aresetn,
    dmem_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         rd_data;
    logic                rd_valid;
    logic                misaligned;

    logic [ADDR_W-1:0]   addr_p0;
    logic [31:0]         wdata_p0;
    logic                wr_en_p0;
    logic [1:0]          count_p0;
    logic                uns_p0;

    logic [31:0]         mem [DEPTH];

    logic                req_mis;
    logic [IDX_W-1:0]    idx;
    logic [31:0]         rd_word;
    logic [31:0]         wr_word;
    logic [3:0]          be;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  count,
                                                input logic [1:0]  lane,
                                                input logic        uns);
        logic [31:0] sh;
        logic [15:0] half;
        sh   = word >> {lane, 3'b000};
        half = lane[1] ? word[31:16] : word[15:0];
        case (count)
            2'd1:    return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd2:    return uns ? {16'd0, half} : {{16{half[15]}}, half};
            default: return word;
        endcase
    endfunction

    assign req_mis = ((bus.i_req_count == 2'd2) && bus.i_req_addr[0]) ||
                     ((bus.i_req_count == 2'd3) && (bus.i_req_addr[1:0] != 2'b00));

    // Word index wraps modulo DEPTH so any depth, not only powers of two, aliases cleanly.
    assign idx     = IDX_W'(addr_p0[ADDR_W-1:2] % (ADDR_W-2)'(DEPTH));
    assign rd_word = mem[idx];

    always_comb begin
        be      = 4'b0000;
        wr_word = wdata_p0;
        case (count_p0)
            2'd1: begin
                be      = 4'b0001 << addr_p0[1:0];
                wr_word = {4{wdata_p0[7:0]}};
            end
            2'd2: begin
                be      = addr_p0[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_p0[15:0]}};
            end
            2'd3:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Stall drops in DONE so the pipeline moves past the request that is still presented.
    assign bus.o_stall      = ((state == IDLE) && (bus.i_req_count != 2'd0)) || (state == WAIT);
    assign bus.o_rd_data    = rd_data;
    assign bus.o_rd_valid   = rd_valid;
    assign bus.o_misaligned = misaligned;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rd_data    <= 32'd0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req_count != 2'd0) begin
                        if (req_mis) begin
                            state      <= DONE;
                            rd_valid   <= 1'b1;
                            misaligned <= 1'b1;
                            rd_data    <= 32'd0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= DONE;
                        rd_valid <= 1'b1;
                        if (!wr_en_p0)
                            rd_data <= load_extend(rd_word, count_p0, addr_p0[1:0], uns_p0);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture at accept; pure data, so no reset.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && (bus.i_req_count != 2'd0)) begin
            addr_p0  <= bus.i_req_addr;
            wdata_p0 <= bus.i_req_wr_data;
            wr_en_p0 <= bus.i_req_wr_en;
            count_p0 <= bus.i_req_count;
            uns_p0   <= bus.i_req_unsigned;
        end
    end

    // Reset forces IDLE, so an aborted store can never reach this write.
    always_ff @(posedge clk) begin
        if ((state == WAIT) && (cnt == 4'd0) && wr_en_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end
endmodule
